addsub_seq: RTL

ADDSUB_SEQ -- requirements
Module: addsub_seq

---
 rtl/addsub_seq_if.sv | 34 +++
 rtl/addsub_seq.sv | 109 ++++++++++
 2 files changed

// File: rtl/addsub_seq_if.sv
// Handshake and datapath bundle between the add/sub sequencer and its environment.
// master = sequencer side, slave = command source / datapath / result consumer side.
interface addsub_seq_if #(
  parameter int unsigned N = 4
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic signed [N-1:0] cmd_a;
  logic signed [N-1:0] cmd_b;
  logic signed [N-1:0] cmd_c;
  logic signed [N-1:0] a;
  logic signed [N-1:0] b;
  logic signed [N-1:0] c;
  logic                SM;
  logic                AS;
  logic                SD;
  logic signed [N:0]   Sum;
  logic signed [N:0]   Sub;
  logic                res_valid;
  logic                res_ready;
  logic signed [N:0]   res_data;
  logic [7:0]          op_count;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c, Sum, Sub, res_ready,
    output cmd_ready, a, b, c, SM, AS, SD, res_valid, res_data, op_count
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c, Sum, Sub, res_ready,
    input  cmd_ready, a, b, c, SM, AS, SD, res_valid, res_data, op_count
  );
endinterface

// File: rtl/addsub_seq.sv
// Command sequencer for an external add/sub datapath: holds operands stable for
// HOLD edges, samples the selected result port, then hands it off to a consumer.
module addsub_seq #(
  parameter int unsigned N    = 4,
  parameter int unsigned HOLD = 4
) (
  input logic          clk,
  input logic          rst,
  addsub_seq_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic signed [N-1:0] a_q, a_d;
  logic signed [N-1:0] b_q, b_d;
  logic signed [N-1:0] c_q, c_d;
  logic                sm_q, sm_d;
  logic                as_q, as_d;
  logic                sd_q, sd_d;
  logic signed [N:0]   res_q, res_d;
  logic [7:0]          ops_q, ops_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      sm_q    <= 1'b0;
      as_q    <= 1'b0;
      sd_q    <= 1'b0;
      res_q   <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sm_q    <= sm_d;
      as_q    <= as_d;
      sd_q    <= sd_d;
      res_q   <= res_d;
      ops_q   <= ops_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sm_d    = sm_q;
    as_d    = as_q;
    sd_d    = sd_q;
    res_d   = res_q;
    ops_d   = ops_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          a_d     = bus.cmd_a;
          b_d     = bus.cmd_b;
          c_d     = bus.cmd_c;
          sm_d    = bus.cmd_op[1];
          as_d    = bus.cmd_op[0];
          sd_d    = bus.cmd_op[0];
          cnt_d   = 4'(HOLD - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Sampling on the zero-count edge lands exactly HOLD edges after acceptance.
        if (cnt_q == 4'd0) begin
          res_d   = sd_q ? bus.Sub : bus.Sum;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          ops_d   = ops_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_q;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.c         = c_q;
  assign bus.SM        = sm_q;
  assign bus.AS        = as_q;
  assign bus.SD        = sd_q;
  assign bus.op_count  = ops_q;

endmodule
